// File: rtl/br_comp_pkg.sv
// Shared constants, the (lt, eq) pair type and the leaf/merge helpers
// used by the branch comparator tree.
package br_comp_pkg;

    localparam int XLEN   = 32;
    localparam int NIBBLE = 4;

    typedef struct packed {
        logic lt;
        logic eq;
    } cmp_t;

    // MSB-first ripple over one leaf: a lower bit only matters while all higher bits match.
    function automatic cmp_t nib_cmp(input logic [NIBBLE-1:0] a, input logic [NIBBLE-1:0] b);
        cmp_t r;
        r.lt = 1'b0;
        r.eq = 1'b1;
        for (int i = NIBBLE - 1; i >= 0; i--) begin
            r.lt = r.lt | (r.eq & ~a[i] & b[i]);
            r.eq = r.eq & ~(a[i] ^ b[i]);
        end
        return r;
    endfunction

    function automatic cmp_t cmp_merge(input cmp_t hi, input cmp_t lo);
        cmp_t r;
        r.lt = hi.lt | (hi.eq & lo.lt);
        r.eq = hi.eq & lo.eq;
        return r;
    endfunction

endpackage

// File: rtl/br_comp_mag.sv
// Unsigned magnitude comparator: 4-bit leaf cells merged pairwise in a
// balanced tree. Operands are zero-extended to a power-of-two leaf count.
module br_comp_mag
    import br_comp_pkg::*;
#(
    parameter int WIDTH = br_comp_pkg::XLEN
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             lt,
    output logic             eq
);

    localparam int NLEAF  = (WIDTH + NIBBLE - 1) / NIBBLE;
    localparam int LEVELS = (NLEAF > 1) ? $clog2(NLEAF) : 0;
    localparam int NPAD   = 1 << LEVELS;
    localparam int EXT_W  = NPAD * NIBBLE;

    logic [EXT_W-1:0] a_ext;
    logic [EXT_W-1:0] b_ext;
    cmp_t             leaf_res [NPAD];
    cmp_t             tree     [LEVELS+1][NPAD];

    // Padding leaves compare zero against zero, so they report equal and never less.
    always_comb begin
        a_ext            = '0;
        b_ext            = '0;
        a_ext[WIDTH-1:0] = a;
        b_ext[WIDTH-1:0] = b;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NPAD; gi++) begin : g_leaf
            assign leaf_res[gi] = nib_cmp(a_ext[gi*NIBBLE +: NIBBLE], b_ext[gi*NIBBLE +: NIBBLE]);
        end
    endgenerate

    // Node i of a level covers children 2i (less significant) and 2i+1 (more significant).
    always_comb begin
        for (int l = 0; l <= LEVELS; l++) begin
            for (int i = 0; i < NPAD; i++) begin
                tree[l][i] = '0;
            end
        end
        for (int i = 0; i < NPAD; i++) begin
            tree[0][i] = leaf_res[i];
        end
        for (int l = 1; l <= LEVELS; l++) begin
            for (int i = 0; i < (NPAD >> l); i++) begin
                tree[l][i] = cmp_merge(tree[l-1][2*i+1], tree[l-1][2*i]);
            end
        end
    end

    assign lt = tree[LEVELS][0].lt;
    assign eq = tree[LEVELS][0].eq;

endmodule

// File: rtl/br_comp.sv
// RV32I branch comparator: combinational less/equal flags plus a registered
// trace copy. Define BR_COMP_STATS_EN to add equal/less/compare cycle counters.
module br_comp #(
    parameter int XLEN = br_comp_pkg::XLEN
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            br_unsigned,
    output logic            br_less,
    output logic            br_equal,
    output logic            br_less_q,
`ifdef BR_COMP_STATS_EN
    output logic [31:0]     taken_eq_cnt,
    output logic [31:0]     taken_lt_cnt,
    output logic [31:0]     cmp_cnt,
`endif
    output logic            br_equal_q
);

    import br_comp_pkg::*;

    localparam int MSB = XLEN - 1;

    logic mag_lt;
    logic mag_eq;
    logic sign_diff;
    logic less_raw;
    logic br_less_d;
    logic br_equal_d;

    br_comp_mag #(
        .WIDTH (XLEN)
    ) u_mag (
        .a  (rs1_data),
        .b  (rs2_data),
        .lt (mag_lt),
        .eq (mag_eq)
    );

    // With differing signs the negative operand (MSB set) is the smaller one.
    always_comb begin
        sign_diff = rs1_data[MSB] ^ rs2_data[MSB];
        less_raw  = mag_lt;
        if (!br_unsigned && sign_diff) begin
            less_raw = rs1_data[MSB];
        end
        br_equal = mag_eq;
        br_less  = less_raw & ~mag_eq;
    end

    always_comb begin
        br_less_d  = br_less;
        br_equal_d = br_equal;
        if (i_reset) begin
            br_less_d  = 1'b0;
            br_equal_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        br_less_q  <= br_less_d;
        br_equal_q <= br_equal_d;
    end

`ifdef BR_COMP_STATS_EN
    logic [31:0] taken_eq_cnt_q;
    logic [31:0] taken_lt_cnt_q;
    logic [31:0] cmp_cnt_q;
    logic [31:0] taken_eq_cnt_d;
    logic [31:0] taken_lt_cnt_d;
    logic [31:0] cmp_cnt_d;

    // Counters wrap naturally at 2^32.
    always_comb begin
        taken_eq_cnt_d = taken_eq_cnt_q + {31'd0, br_equal};
        taken_lt_cnt_d = taken_lt_cnt_q + {31'd0, br_less};
        cmp_cnt_d      = cmp_cnt_q + 32'd1;
        if (i_reset) begin
            taken_eq_cnt_d = '0;
            taken_lt_cnt_d = '0;
            cmp_cnt_d      = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        taken_eq_cnt_q <= taken_eq_cnt_d;
        taken_lt_cnt_q <= taken_lt_cnt_d;
        cmp_cnt_q      <= cmp_cnt_d;
    end

    assign taken_eq_cnt = taken_eq_cnt_q;
    assign taken_lt_cnt = taken_lt_cnt_q;
    assign cmp_cnt      = cmp_cnt_q;
`endif

endmodule

// File: tb/tb_br_comp.sv
// Scoreboard bench for br_comp: combinational flags checked in-cycle, registered
// flags (and counters when BR_COMP_STATS_EN is defined) checked after each edge.
module tb_br_comp;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        br_unsigned;
    logic        br_less;
    logic        br_equal;
    logic        br_less_q;
    logic        br_equal_q;
`ifdef BR_COMP_STATS_EN
    logic [31:0] taken_eq_cnt;
    logic [31:0] taken_lt_cnt;
    logic [31:0] cmp_cnt;
    logic [31:0] m_eq_cnt;
    logic [31:0] m_lt_cnt;
    logic [31:0] m_cmp_cnt;
`endif

    typedef struct packed {
        logic lt;
        logic eq;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 i_clk = ~i_clk;

    br_comp dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .br_unsigned  (br_unsigned),
        .br_less      (br_less),
        .br_equal     (br_equal),
        .br_less_q    (br_less_q),
`ifdef BR_COMP_STATS_EN
        .taken_eq_cnt (taken_eq_cnt),
        .taken_lt_cnt (taken_lt_cnt),
        .cmp_cnt      (cmp_cnt),
`endif
        .br_equal_q   (br_equal_q)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One transaction: drive, check the combinational flags, push the expected
    // registered value, clock once, then pop and check the registered outputs.
    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic uns,
                         input logic rst, input string tag);
        logic exp_lt;
        logic exp_eq;
        exp_t e;
        i_reset     = rst;
        rs1_data    = a;
        rs2_data    = b;
        br_unsigned = uns;
        #1;
        exp_lt = uns ? (a < b) : ($signed(a) < $signed(b));
        exp_eq = (a == b);
        check({tag, "/less"},  {31'd0, br_less},  {31'd0, exp_lt});
        check({tag, "/equal"}, {31'd0, br_equal}, {31'd0, exp_eq});
        e.lt = rst ? 1'b0 : exp_lt;
        e.eq = rst ? 1'b0 : exp_eq;
        sb_q.push_back(e);
`ifdef BR_COMP_STATS_EN
        if (rst) begin
            m_eq_cnt  = '0;
            m_lt_cnt  = '0;
            m_cmp_cnt = '0;
        end else begin
            m_eq_cnt  = m_eq_cnt + {31'd0, exp_eq};
            m_lt_cnt  = m_lt_cnt + {31'd0, exp_lt};
            m_cmp_cnt = m_cmp_cnt + 32'd1;
        end
`endif
        @(posedge i_clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "/sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "/less_q"},  {31'd0, br_less_q},  {31'd0, e.lt});
            check({tag, "/equal_q"}, {31'd0, br_equal_q}, {31'd0, e.eq});
        end
`ifdef BR_COMP_STATS_EN
        check({tag, "/eq_cnt"},  taken_eq_cnt, m_eq_cnt);
        check({tag, "/lt_cnt"},  taken_lt_cnt, m_lt_cnt);
        check({tag, "/cmp_cnt"}, cmp_cnt,      m_cmp_cnt);
`endif
        $display("txn %-10s rst=%0b uns=%0b rs1=%08h rs2=%08h less=%0b equal=%0b less_q=%0b equal_q=%0b",
                 tag, rst, uns, a, b, br_less, br_equal, br_less_q, br_equal_q);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        ru;
`ifdef BR_COMP_STATS_EN
        m_eq_cnt  = '0;
        m_lt_cnt  = '0;
        m_cmp_cnt = '0;
`endif
        apply(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, "reset0");
        apply(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, "zero_eq");
        apply(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, "5v3_s");
        apply(32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, "3v5_s");
        apply(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, "msb_u");
        apply(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, "msb_s");
        apply(32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0, "1vmsb_u");
        apply(32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, "1vmsb_s");
        apply(32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0, "eq5_s");
        apply(32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, "eq5_u");
        apply(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, "min_max_s");
        apply(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, "min_max_u");
        apply(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, "m1v0_s");
        apply(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, "m1v0_u");
        apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "m1eq_s");
        apply(32'h1234_5678, 32'h1234_5679, 1'b1, 1'b0, "lsb_u");
        apply(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 1'b0, "negadj_s");
        // Mid-stream reset held for two edges, then released.
        apply(32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, "rst_hold1");
        apply(32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, "rst_hold2");
        apply(32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, "rst_rel");
        for (int i = 0; i < 48; i++) begin
            ra = $urandom;
            rb = $urandom;
            ru = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ (32'h1 << $urandom_range(0, 31));
                2: rb = {~ra[31], ra[30:0]};
                default: ;
            endcase
            apply(ra, rb, ru, 1'($urandom_range(0, 15) == 0), "rand");
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
